// File: rtl/msx_slot_mapper_if.sv
// msx_slot_mapper_if: Z80 slot-bus bundle between the CPU side and the
// slot mapper. SEG_BITS must match the mapper's MAPPER_SEG_BITS.
interface msx_slot_mapper_if #(
    parameter int SEG_BITS = 6
);
    logic                 i_IORQ;
    logic                 i_MERQ;
    logic                 i_RD;
    logic                 i_WR;
    logic [15:0]          i_A;
    logic [7:0]           i_WDATA;
    logic [7:0]           o_RDATA;
    logic                 o_RDATA_OE;
    logic [15:0]          o_SEL;
    logic                 o_MAP_SEL;
    logic [SEG_BITS+13:0] o_MAP_ADDR;

    modport master (
        output i_IORQ, i_MERQ, i_RD, i_WR, i_A, i_WDATA,
        input  o_RDATA, o_RDATA_OE, o_SEL, o_MAP_SEL, o_MAP_ADDR
    );

    modport slave (
        input  i_IORQ, i_MERQ, i_RD, i_WR, i_A, i_WDATA,
        output o_RDATA, o_RDATA_OE, o_SEL, o_MAP_SEL, o_MAP_ADDR
    );
endinterface

// File: rtl/msx_slot_mapper.sv
// msx_slot_mapper: primary/secondary slot decoder with MSX memory mapper.
// Define MSX_MAPPER_READBACK_EN to make mapper ports FCh-FFh readable.
module msx_slot_mapper #(
    parameter logic [3:0] EXPAND_MASK     = 4'b1000,
    parameter int         MAPPER_SEG_BITS = 6,
    parameter int         MAPPER_PSLOT    = 3,
    parameter int         MAPPER_SSLOT    = 0
) (
    input logic               i_CLK,
    input logic               i_RST_n,
    msx_slot_mapper_if.slave  bus
);
    localparam int         SB = MAPPER_SEG_BITS;
    localparam logic [1:0] MP = 2'(MAPPER_PSLOT);
    localparam logic [1:0] MS = 2'(MAPPER_SSLOT);
    localparam logic       MP_EXP = EXPAND_MASK[MP];

    localparam logic [1:0] K_A8  = 2'd0;
    localparam logic [1:0] K_FF  = 2'd1;
    localparam logic [1:0] K_MAP = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPT,
        S_HOLD
    } state_t;

    logic [7:0]    r_pslot;
    logic [7:0]    r_sslot [4];
    logic [SB-1:0] r_seg   [4];

    logic [1:0]    r_wsh;
    logic [1:0]    r_wkind;
    logic [1:0]    r_wk;
    logic [7:0]    r_wdata;

    state_t        r_state;
    logic          r_rd_d;
    logic [1:0]    r_rkind;
    logic [1:0]    r_rk;

    logic          w_io_a8;
    logic          w_io_map;
    logic          w_rd_map;
    logic [1:0]    w_ff_slot;
    logic          w_ff_hit;
    logic          w_wr_hit;
    logic          w_rd_hit;
    logic [1:0]    w_kind;
    logic [7:0]    w_seg_rd;
    logic [7:0]    w_rdval;
    logic [1:0]    w_p;
    logic [1:0]    w_s;
    logic [1:0]    w_ss;
    logic          w_mem;
    logic [15:0]   w_sel;
    logic          w_map;

    assign w_io_a8   = bus.i_IORQ & (bus.i_A[7:0] == 8'hA8);
    assign w_io_map  = bus.i_IORQ & (bus.i_A[7:2] == 6'b111111);
    assign w_ff_slot = r_pslot[7:6];
    assign w_ff_hit  = bus.i_MERQ & (bus.i_A == 16'hFFFF)
                     & EXPAND_MASK[w_ff_slot];

`ifdef MSX_MAPPER_READBACK_EN
    assign w_rd_map = w_io_map;
`else
    assign w_rd_map = 1'b0;
`endif

    assign w_wr_hit = (w_io_a8 | w_io_map | w_ff_hit) & bus.i_WR;
    assign w_rd_hit = (w_io_a8 | w_rd_map | w_ff_hit) & bus.i_RD;

    // Classify the register targeted by the current access.
    always_comb begin
        w_kind = K_MAP;
        if (w_ff_hit)
            w_kind = K_FF;
        else if (w_io_a8)
            w_kind = K_A8;
    end

    // Read-back value; unused upper mapper bits read as ones.
    always_comb begin
        w_seg_rd         = 8'hFF;
        w_seg_rd[SB-1:0] = r_seg[r_rk];
        case (r_rkind)
            K_A8:    w_rdval = r_pslot;
            K_FF:    w_rdval = ~r_sslot[r_pslot[7:6]];
            default: w_rdval = w_seg_rd;
        endcase
    end

    // Page -> primary slot -> subslot decode for the current address.
    always_comb begin
        w_p   = bus.i_A[15:14];
        w_s   = r_pslot[{w_p, 1'b0} +: 2];
        w_ss  = EXPAND_MASK[w_s] ? r_sslot[w_s][{w_p, 1'b0} +: 2] : 2'd0;
        w_mem = bus.i_MERQ & ~w_ff_hit;
        w_sel = '0;
        if (w_mem)
            w_sel[{w_s, w_ss}] = 1'b1;
        w_map = w_mem & (w_s == MP) & ((w_ss == MS) | ~MP_EXP);
    end

    // Write path: capture on strobe rise, commit once on the 01 pattern.
    always_ff @(posedge i_CLK) begin
        if (!i_RST_n) begin
            r_wsh   <= 2'b00;
            r_wkind <= K_A8;
            r_wk    <= 2'd0;
            r_wdata <= 8'h00;
            r_pslot <= 8'h00;
            for (int i = 0; i < 4; i++) begin
                r_sslot[i] <= 8'h00;
                r_seg[i]   <= SB'(3 - i);
            end
        end else begin
            r_wsh <= {r_wsh[0], w_wr_hit};
            if (w_wr_hit & ~r_wsh[0]) begin
                r_wkind <= w_kind;
                r_wk    <= bus.i_A[1:0];
                r_wdata <= bus.i_WDATA;
            end
            if (r_wsh == 2'b01) begin
                case (r_wkind)
                    K_A8:    r_pslot <= r_wdata;
                    K_FF:    r_sslot[r_pslot[7:6]] <= r_wdata;
                    default: r_seg[r_wk] <= r_wdata[SB-1:0];
                endcase
            end
        end
    end

    // Read FSM: capture one cycle after the strobe rise, hold while RD.
    always_ff @(posedge i_CLK) begin
        if (!i_RST_n) begin
            r_state        <= S_IDLE;
            r_rd_d         <= 1'b0;
            r_rkind        <= K_A8;
            r_rk           <= 2'd0;
            bus.o_RDATA    <= 8'h00;
            bus.o_RDATA_OE <= 1'b0;
        end else begin
            r_rd_d <= w_rd_hit;
            case (r_state)
                S_IDLE: begin
                    if (w_rd_hit & ~r_rd_d & ~bus.i_WR) begin
                        r_state <= S_CAPT;
                        r_rkind <= w_kind;
                        r_rk    <= bus.i_A[1:0];
                    end
                end
                S_CAPT: begin
                    bus.o_RDATA    <= w_rdval;
                    bus.o_RDATA_OE <= 1'b1;
                    r_state        <= S_HOLD;
                end
                S_HOLD: begin
                    if (!bus.i_RD) begin
                        bus.o_RDATA_OE <= 1'b0;
                        r_state        <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Registered slot selects and physical mapper address.
    always_ff @(posedge i_CLK) begin
        if (!i_RST_n) begin
            bus.o_SEL      <= 16'h0000;
            bus.o_MAP_SEL  <= 1'b0;
            bus.o_MAP_ADDR <= '0;
        end else begin
            bus.o_SEL      <= w_sel;
            bus.o_MAP_SEL  <= w_map;
            bus.o_MAP_ADDR <= {r_seg[w_p], bus.i_A[13:0]};
        end
    end
endmodule

// File: tb/tb_msx_slot_mapper.sv
// tb_msx_slot_mapper: directed tests of slot decode, subslots,
// mapper segments, write-once strobes, read FSM and reset.
module tb_msx_slot_mapper;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    msx_slot_mapper_if #(.SEG_BITS(6)) bus ();

    msx_slot_mapper dut (
        .i_CLK   (clk),
        .i_RST_n (rst_n),
        .bus     (bus)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.i_IORQ  = 1'b0;
        bus.i_MERQ  = 1'b0;
        bus.i_RD    = 1'b0;
        bus.i_WR    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        bus.i_A     = 16'h0000;
        bus.i_WDATA = 8'h00;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic do_write(input bit io, input logic [15:0] a,
                            input logic [7:0] d);
        bus.i_IORQ  = io;
        bus.i_MERQ  = !io;
        bus.i_A     = a;
        bus.i_WDATA = d;
        bus.i_WR    = 1'b1;
        cyc(2);
        drive_idle();
        cyc(2);
    endtask

    task automatic start_read(input bit io, input logic [15:0] a);
        bus.i_IORQ = io;
        bus.i_MERQ = !io;
        bus.i_A    = a;
        bus.i_RD   = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        bus.i_A = 16'h0000;
        cyc(2);
        n_tests++;
        if (bus.o_RDATA !== 8'h00 || bus.o_RDATA_OE !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rd: got %h/%b want 00/0",
                     bus.o_RDATA, bus.o_RDATA_OE);
        end
        n_tests++;
        if (bus.o_SEL !== 16'h0000 || bus.o_MAP_SEL !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_sel: got %h/%b want 0000/0",
                     bus.o_SEL, bus.o_MAP_SEL);
        end
        rst_n = 1'b1;
        cyc(1);
        n_tests++;
        if (bus.o_MAP_ADDR !== 20'h0C000) begin
            n_fail++;
            $display("FAIL reset_seg0: got %h want 0c000",
                     bus.o_MAP_ADDR);
        end
    endtask

    task automatic test_a8_rw();
        do_reset();
        do_write(1'b1, 16'h00A8, 8'hFF);
        start_read(1'b1, 16'h00A8);
        cyc(1);
        n_tests++;
        if (bus.o_RDATA_OE !== 1'b0) begin
            n_fail++;
            $display("FAIL a8_oe_early: got %b want 0", bus.o_RDATA_OE);
        end
        cyc(1);
        n_tests++;
        if (bus.o_RDATA !== 8'hFF || bus.o_RDATA_OE !== 1'b1) begin
            n_fail++;
            $display("FAIL a8_read: got %h/%b want ff/1",
                     bus.o_RDATA, bus.o_RDATA_OE);
        end
        cyc(3);
        n_tests++;
        if (bus.o_RDATA_OE !== 1'b1) begin
            n_fail++;
            $display("FAIL a8_hold: got %b want 1", bus.o_RDATA_OE);
        end
        drive_idle();
        cyc(1);
        n_tests++;
        if (bus.o_RDATA_OE !== 1'b0) begin
            n_fail++;
            $display("FAIL a8_release: got %b want 0", bus.o_RDATA_OE);
        end
        cyc(1);
    endtask

    task automatic test_subslot();
        do_reset();
        do_write(1'b1, 16'h00A8, 8'hC0);
        do_write(1'b0, 16'hFFFF, 8'h00);
        start_read(1'b0, 16'hFFFF);
        cyc(1);
        n_tests++;
        if (bus.o_SEL !== 16'h0000) begin
            n_fail++;
            $display("FAIL ff_shadow: got %h want 0000", bus.o_SEL);
        end
        cyc(1);
        n_tests++;
        if (bus.o_RDATA !== 8'hFF || bus.o_RDATA_OE !== 1'b1) begin
            n_fail++;
            $display("FAIL ff_read00: got %h/%b want ff/1",
                     bus.o_RDATA, bus.o_RDATA_OE);
        end
        drive_idle();
        cyc(2);
        do_write(1'b0, 16'hFFFF, 8'h80);
        start_read(1'b0, 16'hC000);
        cyc(1);
        n_tests++;
        if (bus.o_SEL !== 16'h4000 || bus.o_MAP_SEL !== 1'b0) begin
            n_fail++;
            $display("FAIL sub2_sel: got %h/%b want 4000/0",
                     bus.o_SEL, bus.o_MAP_SEL);
        end
        drive_idle();
        cyc(1);
        start_read(1'b0, 16'hFFFF);
        cyc(2);
        n_tests++;
        if (bus.o_RDATA !== 8'h7F) begin
            n_fail++;
            $display("FAIL ff_read80: got %h want 7f", bus.o_RDATA);
        end
        drive_idle();
        cyc(2);
    endtask

    task automatic test_mapper_decode();
        do_reset();
        do_write(1'b1, 16'h00A8, 8'h54);
        start_read(1'b0, 16'h4000);
        cyc(1);
        n_tests++;
        if (bus.o_SEL !== 16'h0010 || bus.o_MAP_SEL !== 1'b0 ||
            bus.o_MAP_ADDR !== 20'h08000) begin
            n_fail++;
            $display("FAIL dec_54: got %h/%b/%h want 0010/0/08000",
                     bus.o_SEL, bus.o_MAP_SEL, bus.o_MAP_ADDR);
        end
        drive_idle();
        cyc(1);
        do_write(1'b1, 16'h00A8, 8'h0C);
        start_read(1'b0, 16'h4000);
        cyc(1);
        n_tests++;
        if (bus.o_SEL !== 16'h1000 || bus.o_MAP_SEL !== 1'b1 ||
            bus.o_MAP_ADDR !== 20'h08000) begin
            n_fail++;
            $display("FAIL dec_map: got %h/%b/%h want 1000/1/08000",
                     bus.o_SEL, bus.o_MAP_SEL, bus.o_MAP_ADDR);
        end
        drive_idle();
        cyc(1);
        do_write(1'b1, 16'h00FD, 8'h47);
        start_read(1'b0, 16'h4000);
        cyc(1);
        n_tests++;
        if (bus.o_MAP_ADDR !== 20'h1C000) begin
            n_fail++;
            $display("FAIL seg_wrap: got %h want 1c000", bus.o_MAP_ADDR);
        end
        bus.i_A = 16'h7FFF;
        cyc(1);
        n_tests++;
        if (bus.o_MAP_ADDR !== 20'h1FFFF || bus.o_MAP_SEL !== 1'b1) begin
            n_fail++;
            $display("FAIL seg_top: got %h/%b want 1ffff/1",
                     bus.o_MAP_ADDR, bus.o_MAP_SEL);
        end
        drive_idle();
        cyc(1);
    endtask

    task automatic test_seg_readback();
        do_reset();
        start_read(1'b1, 16'h00FE);
        cyc(2);
`ifdef MSX_MAPPER_READBACK_EN
        n_tests++;
        if (bus.o_RDATA !== 8'hC1 || bus.o_RDATA_OE !== 1'b1) begin
            n_fail++;
            $display("FAIL fe_read: got %h/%b want c1/1",
                     bus.o_RDATA, bus.o_RDATA_OE);
        end
`else
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (bus.o_RDATA_OE !== 1'b0) begin
                n_fail++;
                $display("FAIL fe_noread: got %b want 0", bus.o_RDATA_OE);
            end
            cyc(1);
        end
`endif
        drive_idle();
        cyc(2);
    endtask

    task automatic test_long_write();
        do_reset();
        bus.i_IORQ  = 1'b1;
        bus.i_A     = 16'h00FC;
        bus.i_WDATA = 8'h05;
        bus.i_WR    = 1'b1;
        cyc(2);
        n_tests++;
        if (bus.o_MAP_ADDR[19:14] !== 6'd3) begin
            n_fail++;
            $display("FAIL lw_early: got %0d want 3", bus.o_MAP_ADDR[19:14]);
        end
        cyc(1);
        n_tests++;
        if (bus.o_MAP_ADDR[19:14] !== 6'd5) begin
            n_fail++;
            $display("FAIL lw_land: got %0d want 5", bus.o_MAP_ADDR[19:14]);
        end
        bus.i_WDATA = 8'h09;
        cyc(17);
        n_tests++;
        if (bus.o_MAP_ADDR[19:14] !== 6'd5) begin
            n_fail++;
            $display("FAIL lw_once: got %0d want 5", bus.o_MAP_ADDR[19:14]);
        end
        drive_idle();
        cyc(3);
        n_tests++;
        if (bus.o_MAP_ADDR[19:14] !== 6'd5) begin
            n_fail++;
            $display("FAIL lw_after: got %0d want 5", bus.o_MAP_ADDR[19:14]);
        end
    endtask

    task automatic test_write_wins();
        do_reset();
        bus.i_IORQ  = 1'b1;
        bus.i_A     = 16'h00A8;
        bus.i_WDATA = 8'h3C;
        bus.i_WR    = 1'b1;
        bus.i_RD    = 1'b1;
        cyc(4);
        n_tests++;
        if (bus.o_RDATA_OE !== 1'b0) begin
            n_fail++;
            $display("FAIL ww_oe: got %b want 0", bus.o_RDATA_OE);
        end
        drive_idle();
        cyc(1);
        start_read(1'b0, 16'h8000);
        cyc(1);
        n_tests++;
        if (bus.o_SEL !== 16'h1000 || bus.o_MAP_SEL !== 1'b1) begin
            n_fail++;
            $display("FAIL ww_dec: got %h/%b want 1000/1",
                     bus.o_SEL, bus.o_MAP_SEL);
        end
        drive_idle();
        cyc(1);
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        do_write(1'b1, 16'h00A8, 8'hFF);
        start_read(1'b1, 16'h00A8);
        cyc(3);
        n_tests++;
        if (bus.o_RDATA_OE !== 1'b1) begin
            n_fail++;
            $display("FAIL rh_hold: got %b want 1", bus.o_RDATA_OE);
        end
        rst_n = 1'b0;
        cyc(1);
        n_tests++;
        if (bus.o_RDATA_OE !== 1'b0 || bus.o_RDATA !== 8'h00) begin
            n_fail++;
            $display("FAIL rh_reset: got %b/%h want 0/00",
                     bus.o_RDATA_OE, bus.o_RDATA);
        end
        drive_idle();
        cyc(1);
        rst_n = 1'b1;
        start_read(1'b0, 16'hC000);
        cyc(1);
        n_tests++;
        if (bus.o_SEL !== 16'h0001) begin
            n_fail++;
            $display("FAIL rh_pslot: got %h want 0001", bus.o_SEL);
        end
        drive_idle();
        cyc(1);
    endtask

    initial begin
        drive_idle();
        bus.i_A     = 16'h0000;
        bus.i_WDATA = 8'h00;
        test_reset();
        test_a8_rw();
        test_subslot();
        test_mapper_decode();
        test_seg_readback();
        test_long_write();
        test_write_wins();
        test_reset_in_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
